// File: rtl/coffee_pkg.sv
// Shared types for the coffee machine dispense path: ingredient indices,
// recipe mask, sequencer state encoding and the next-ingredient search.
package coffee_pkg;

   typedef enum logic [2:0] {
      ING_WATER  = 3'd0,
      ING_COFFEE = 3'd1,
      ING_SUGAR  = 3'd2,
      ING_MILK   = 3'd3,
      ING_CHOC   = 3'd4
   } ingredient_e;

   // Bit i set means ingredient i is requested: {choc, milk, sugar, coffee, water}
   typedef logic [4:0] recipe_mask_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   localparam logic [2:0] STEP_IDLE = 3'd7;

   // Lowest set bit wins, giving the fixed water->chocolate dispense order
   function automatic ingredient_e first_ing(input recipe_mask_t m);
      ingredient_e r;
      r = ING_WATER;
      for (int i = 4; i >= 0; i--) begin
         if (m[i]) r = ingredient_e'(3'(i));
      end
      return r;
   endfunction

   function automatic recipe_mask_t ing_bit(input ingredient_e i);
      return recipe_mask_t'(5'b00001 << i);
   endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Request / valve-drive bundle between the recipe controller and the
// dispense sequencer.
interface dispense_sequencer_if;

   logic       start;
   logic       req_water;
   logic       req_coffee;
   logic       req_sugar;
   logic       req_milk;
   logic       req_chocolate;
   logic       abort;
   logic       valve_water;
   logic       valve_coffee;
   logic       valve_sugar;
   logic       valve_milk;
   logic       valve_chocolate;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [2:0] step;

   modport master (
      output start, req_water, req_coffee, req_sugar, req_milk, req_chocolate, abort,
      input  valve_water, valve_coffee, valve_sugar, valve_milk, valve_chocolate,
      input  busy, done, aborted, step
   );

   modport slave (
      input  start, req_water, req_coffee, req_sugar, req_milk, req_chocolate, abort,
      output valve_water, valve_coffee, valve_sugar, valve_milk, valve_chocolate,
      output busy, done, aborted, step
   );

endinterface

// File: rtl/step_timer.sv
// Loadable down-counter timing one valve phase. expire is high during the
// last cycle of a loaded interval (counter value 1), so a load of N yields
// an interval of exactly N cycles.
module step_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load takes priority; otherwise count down and rest at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // Counter register
   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dispense_sequencer.sv
// Turns a latched recipe mask into timed, mutually exclusive valve pulses,
// one ingredient at a time in water->coffee->sugar->milk->chocolate order,
// followed by a one-cycle done pulse. abort drops all valves at once.
module dispense_sequencer
   import coffee_pkg::*;
#(
   parameter int T_WATER  = 8,
   parameter int T_COFFEE = 4,
   parameter int T_SUGAR  = 2,
   parameter int T_MILK   = 3,
   parameter int T_CHOC   = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   dispense_sequencer_if.slave  bus
);

   localparam int T_MAX_A = (T_WATER > T_COFFEE) ? T_WATER : T_COFFEE;
   localparam int T_MAX_B = (T_SUGAR > T_MILK) ? T_SUGAR : T_MILK;
   localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int T_MAX   = (T_MAX_C > T_CHOC) ? T_MAX_C : T_CHOC;
   localparam int CNT_W   = $clog2(T_MAX + 1);

   function automatic logic [CNT_W-1:0] dur(input ingredient_e i);
      case (i)
         ING_WATER:  dur = CNT_W'(T_WATER);
         ING_COFFEE: dur = CNT_W'(T_COFFEE);
         ING_SUGAR:  dur = CNT_W'(T_SUGAR);
         ING_MILK:   dur = CNT_W'(T_MILK);
         default:    dur = CNT_W'(T_CHOC);
      endcase
   endfunction

   seq_state_e       state_q, state_d;
   recipe_mask_t     rem_q, rem_d;      // requested ingredients not yet dispensed
   ingredient_e      cur_q, cur_d;      // ingredient whose valve is open
   recipe_mask_t     valve_q, valve_d;
   logic [2:0]       step_q, step_d;
   logic             aborted_q, aborted_d;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             expire;
   recipe_mask_t     req_mask;
   ingredient_e      nxt;

   assign req_mask = {bus.req_chocolate, bus.req_milk, bus.req_sugar,
                      bus.req_coffee, bus.req_water};

   step_timer #(.CNT_W(CNT_W)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   // State and registered-output flops
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         cur_q     <= ING_WATER;
         valve_q   <= '0;
         step_q    <= STEP_IDLE;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         cur_q     <= cur_d;
         valve_q   <= valve_d;
         step_q    <= step_d;
         aborted_q <= aborted_d;
      end
   end

   // Next state: accept start in IDLE, chain ingredients on timer expiry, abort to IDLE
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      cur_d    = cur_q;
      load     = 1'b0;
      load_val = '0;
      nxt      = ING_WATER;
      case (state_q)
         IDLE: begin
            // abort on the same edge suppresses the start
            if (bus.start && !bus.abort) begin
               rem_d = req_mask;
               if (req_mask != '0) begin
                  nxt      = first_ing(req_mask);
                  cur_d    = nxt;
                  rem_d    = req_mask & ~ing_bit(nxt);
                  load     = 1'b1;
                  load_val = dur(nxt);
                  state_d  = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
               rem_d   = '0;
            end else if (expire) begin
               // Skipped ingredients cost no cycles: the next valve opens right after expiry
               if (rem_q != '0) begin
                  nxt      = first_ing(rem_q);
                  cur_d    = nxt;
                  rem_d    = rem_q & ~ing_bit(nxt);
                  load     = 1'b1;
                  load_val = dur(nxt);
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            rem_d   = '0;
         end
         default: begin
            state_d = IDLE;
            rem_d   = '0;
         end
      endcase
   end

   // Outputs for next cycle: one-hot valve only while running, aborted pulse on abort
   always_comb begin
      valve_d   = '0;
      step_d    = STEP_IDLE;
      aborted_d = (state_q != IDLE) && bus.abort;
      if (state_d == RUN) begin
         valve_d = ing_bit(cur_d);
         step_d  = 3'(cur_d);
      end
   end

   assign bus.valve_water     = valve_q[0];
   assign bus.valve_coffee    = valve_q[1];
   assign bus.valve_sugar     = valve_q[2];
   assign bus.valve_milk      = valve_q[3];
   assign bus.valve_chocolate = valve_q[4];
   assign bus.busy            = (state_q != IDLE);
   assign bus.done            = (state_q == DONE);
   assign bus.aborted         = aborted_q;
   assign bus.step            = step_q;

endmodule
